// File: rtl/trafficlight_param.sv
// Parametrised pedestrian-crossing traffic light with min-green, request flag,
// countdown output and blinking-yellow night mode, all timed from a prescaler tick.
module trafficlight_param #(
  parameter int PW      = 24,
  parameter int PDIV    = 8388608,
  parameter int CW      = 5,
  parameter int T_GMIN  = 5,
  parameter int T_Y     = 2,
  parameter int T_R     = 15,
  parameter int T_BLINK = 1
) (
  input  logic          C,
  input  logic          nR,
  input  logic          nB,
  input  logic          nNight,
  output logic          nGQ,
  output logic          nEQ,
  output logic          nRQ,
  output logic          nTY,
  output logic [CW-1:0] CNT,
  output logic          REQ
);

  localparam logic [2:0] S_GMIN  = 3'd0;
  localparam logic [2:0] S_GWAIT = 3'd1;
  localparam logic [2:0] S_YEL   = 3'd2;
  localparam logic [2:0] S_RED   = 3'd3;
  localparam logic [2:0] S_NIGHT = 3'd4;

  localparam int BW = (T_BLINK < 2) ? 1 : $clog2(T_BLINK + 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          b_s1, b_s2, b_s3;
  logic          n_s1, n_s2;
  logic          press, night;
  logic [2:0]    state;
  logic          nflag;
  logic          blink;
  logic [BW-1:0] bcnt;

  assign tick  = (pcnt == PW'(PDIV - 1));
  assign press = b_s3 & ~b_s2;
  assign night = ~n_s2;

  always_ff @(posedge C) begin
    if (!nR)       pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  always_ff @(posedge C) begin
    if (!nR) begin
      {b_s1, b_s2, b_s3} <= '1;
      {n_s1, n_s2}       <= '1;
    end else begin
      {b_s1, b_s2, b_s3} <= {nB, b_s1, b_s2};
      {n_s1, n_s2}       <= {nNight, n_s1};
    end
  end

  always_ff @(posedge C) begin
    if (!nR) begin
      state <= S_GMIN;
      CNT   <= CW'(T_GMIN);
      REQ   <= 1'b0;
      nflag <= 1'b0;
      blink <= 1'b0;
      bcnt  <= BW'(T_BLINK);
    end else begin
      case (state)
        S_GMIN, S_GWAIT: begin
          if (press) REQ <= 1'b1;
          // Decision point: end of min-green, or any tick while waiting.
          if (tick && (state == S_GWAIT || CNT == CW'(1))) begin
            if (night || REQ) begin
              state <= S_YEL;
              CNT   <= CW'(T_Y);
              REQ   <= 1'b0;
              nflag <= night;
            end else begin
              state <= S_GWAIT;
              CNT   <= '0;
            end
          end else if (tick) begin
            CNT <= CNT - CW'(1);
          end
        end
        S_YEL: begin
          if (tick) begin
            if (CNT == CW'(1)) begin
              if (nflag) begin
                state <= S_NIGHT;
                CNT   <= '0;
                nflag <= 1'b0;
                blink <= 1'b1;
                bcnt  <= BW'(T_BLINK);
              end else begin
                state <= S_RED;
                CNT   <= CW'(T_R);
              end
            end else begin
              CNT <= CNT - CW'(1);
            end
          end
        end
        S_RED: begin
          if (tick) begin
            if (CNT == CW'(1)) begin
              if (night) begin
                state <= S_NIGHT;
                CNT   <= '0;
                nflag <= 1'b0;
                blink <= 1'b1;
                bcnt  <= BW'(T_BLINK);
              end else begin
                state <= S_GMIN;
                CNT   <= CW'(T_GMIN);
              end
            end else begin
              CNT <= CNT - CW'(1);
            end
          end
        end
        S_NIGHT: begin
          if (tick) begin
            if (!night) begin
              state <= S_RED;
              CNT   <= CW'(T_R);
              blink <= 1'b0;
            end else if (bcnt == BW'(1)) begin
              blink <= ~blink;
              bcnt  <= BW'(T_BLINK);
            end else begin
              bcnt <= bcnt - BW'(1);
            end
          end
        end
        default: begin
          state <= S_GMIN;
          CNT   <= CW'(T_GMIN);
          nflag <= 1'b0;
          blink <= 1'b0;
        end
      endcase
    end
  end

  assign nGQ = ~(state == S_GMIN || state == S_GWAIT);
  assign nEQ = ~(state == S_YEL || (state == S_NIGHT && blink));
  assign nRQ = ~(state == S_RED);
  assign nTY = (CNT == '0);

endmodule

// File: tb/tb_trafficlight_param.sv
// Randomised bench for trafficlight_param against a tick/phase-level reference model.
module tb_trafficlight_param;

  localparam int PDIV = 4, CW = 4, T_GMIN = 3, T_Y = 2, T_R = 5, T_BLINK = 2;

  logic          C = 1'b0;
  logic          nR, nB, nNight;
  logic          nGQ, nEQ, nRQ, nTY, REQ;
  logic [CW-1:0] CNT;

  trafficlight_param #(
    .PW(4), .PDIV(PDIV), .CW(CW), .T_GMIN(T_GMIN), .T_Y(T_Y), .T_R(T_R), .T_BLINK(T_BLINK)
  ) dut (
    .C(C), .nR(nR), .nB(nB), .nNight(nNight),
    .nGQ(nGQ), .nEQ(nEQ), .nRQ(nRQ), .nTY(nTY), .CNT(CNT), .REQ(REQ)
  );

  always #5 C = ~C;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases with remaining-tick counts, inputs as edge-sample history.
  typedef enum {M_GMIN, M_GWAIT, M_YEL, M_RED, M_NIGHT} mph_t;
  mph_t m_ph;
  int   m_left, m_cyc, m_nt;
  bit   m_req, m_nflag;
  bit   bh [3];
  bit   nh [2];

  task automatic model_step();
    bit press, nt_on, tk, r_old;
    if (!nR) begin
      m_ph = M_GMIN; m_left = T_GMIN; m_req = 0; m_nflag = 0; m_cyc = 0; m_nt = 0;
      bh = '{1, 1, 1}; nh = '{1, 1};
      return;
    end
    press = bh[2] && !bh[1];
    nt_on = !nh[1];
    tk    = (m_cyc % PDIV) == PDIV - 1;
    m_cyc++;
    bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = nB;
    nh[1] = nh[0]; nh[0] = nNight;
    r_old = m_req;
    if ((m_ph == M_GMIN || m_ph == M_GWAIT) && press) m_req = 1;
    if (!tk) return;
    if (m_ph == M_GMIN) m_left--;
    case (m_ph)
      M_GMIN, M_GWAIT:
        if (m_ph == M_GWAIT || m_left == 0) begin
          if (nt_on || r_old) begin
            m_ph = M_YEL; m_left = T_Y; m_req = 0; m_nflag = nt_on;
          end else begin
            m_ph = M_GWAIT; m_left = 0;
          end
        end
      M_YEL: begin
        m_left--;
        if (m_left == 0) begin
          if (m_nflag) begin m_ph = M_NIGHT; m_nflag = 0; m_nt = 0; end
          else begin m_ph = M_RED; m_left = T_R; end
        end
      end
      M_RED: begin
        m_left--;
        if (m_left == 0) begin
          if (nt_on) begin m_ph = M_NIGHT; m_nt = 0; end
          else begin m_ph = M_GMIN; m_left = T_GMIN; end
        end
      end
      M_NIGHT:
        if (!nt_on) begin m_ph = M_RED; m_left = T_R; end
        else m_nt++;
    endcase
  endtask

  task automatic compare();
    bit g, e, r;
    g = (m_ph == M_GMIN || m_ph == M_GWAIT);
    r = (m_ph == M_RED);
    e = (m_ph == M_YEL) || (m_ph == M_NIGHT && ((m_nt / T_BLINK) % 2) == 0);
    chk("lamps", {29'd0, nGQ, nEQ, nRQ}, {29'd0, !g, !e, !r});
    chk("cnt",   {28'd0, CNT}, m_left);
    chk("nty",   {31'd0, nTY}, {31'd0, m_left == 0});
    chk("req",   {31'd0, REQ}, {31'd0, m_req});
  endtask

  task automatic cycle();
    @(posedge C);
    model_step();
    @(negedge C);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_for(input int n);
    nB = 1'b0; run(n); nB = 1'b1;
  endtask

  int press_left;
  bit found;

  initial begin
    m_ph = M_GMIN; m_left = T_GMIN; m_req = 0; m_nflag = 0; m_cyc = 0; m_nt = 0;
    bh = '{1, 1, 1}; nh = '{1, 1};
    nR = 1'b0; nB = 1'b1; nNight = 1'b1;
    run(2);
    chk("rst_cnt", {28'd0, CNT}, 32'd3);
    chk("rst_lamps", {29'd0, nGQ, nEQ, nRQ}, 32'b011);
    nR = 1'b1;
    run(20);
    chk("gwait_cnt", {28'd0, CNT}, 32'd0);

    // Press in GRN_WAIT, then follow the full yellow/red/green cycle.
    press_for(1);
    run(60);

    // Press while red must be ignored.
    press_for(2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      found = (m_ph == M_RED);
    end
    chk("wait_red1", {31'd0, found}, 32'd1);
    press_for(3);
    chk("red_req", {31'd0, REQ}, 32'd0);
    run(60);

    // Night mode entry, blinking, and exit through red.
    nNight = 1'b0;
    run(140);
    nNight = 1'b1;
    run(80);

    // Reset in the middle of red.
    press_for(1);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle();
      found = (m_ph == M_RED && m_left == 3);
    end
    chk("wait_red3", {31'd0, found}, 32'd1);
    nR = 1'b0;
    run(1);
    nR = 1'b1;
    chk("midrst_cnt", {28'd0, CNT}, 32'd3);
    chk("midrst_g", {31'd0, nGQ}, 32'd0);
    run(10);

    // Random mix of presses, night switching and occasional resets.
    press_left = 0;
    for (int i = 0; i < 5000; i++) begin
      if (press_left > 0) begin
        nB = 1'b0; press_left--;
      end else begin
        nB = 1'b1;
        if ($urandom_range(0, 29) == 0) press_left = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 249) == 0) nNight = ~nNight;
      nR = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trafficlight_param.md
Name: trafficlight_param

Overview:
Parametrised successor to the single-crossing pedestrian traffic light. Runs from the board clock C and derives its state timing from an internal prescaler tick, not a derived clock. Adds configurable phase durations, a minimum-green guarantee, a request flag, a countdown output and a blinking-yellow night mode. Sits at top level, driving three active-low lamps plus a timing LED, with the pedestrian button and night switch as inputs.

Parameters:
PW, 24, prescaler counter width.
PDIV, 8388608, C cycles per TICK; range 1..2^PW.
CW, 5, phase counter / CNT width; must hold the largest T_*.
T_GMIN, 5, minimum green duration in TICKs; must be >=1.
T_Y, 2, yellow duration in TICKs; must be >=1.
T_R, 15, red duration in TICKs; must be >=1.
T_BLINK, 1, night-mode yellow half-period in TICKs; must be >=1.

Ports:
C  input  1  system clock; all logic on posedge C.
nR  input  1  reset; synchronous, active-low.
nB  input  1  pedestrian button; asynchronous, active-low.
nNight  input  1  night-mode switch; asynchronous, active-low; level-sensitive.
nGQ  output  1  green lamp; active-low.
nEQ  output  1  yellow lamp; active-low.
nRQ  output  1  red lamp; active-low.
nTY  output  1  timing LED; low while CNT!=0.
CNT  output  CW  remaining TICKs of the current timed phase; 0 in untimed states.
REQ  output  1  pedestrian request pending.

Behaviour:
- Reset: one cycle of nR=0 at posedge C gives the following. State GRN_MIN, CNT=T_GMIN, nGQ=0, nEQ=1, nRQ=1, nTY=0, REQ=0, prescaler=0, blink phase=0. Sync flops preset to 1 (released). Reset overrides TICK, press and night in the same cycle. Reset mid-phase abandons the phase immediately.
- Prescaler: counts 0..PDIV-1 and wraps. TICK is a one-cycle pulse when the count is PDIV-1. PDIV=1 gives TICK every cycle.
- Input sync: nB and nNight each pass through 2 flops. A press is a 1->0 edge of synced nB, detected with a third flop. Night is the synced nNight level being 0.
- REQ handling:
  - Set by a press in GRN_MIN or GRN_WAIT.
  - Cleared on entry to YEL.
  - Presses in YEL, RED or NIGHT are ignored.
  - If a press and the YEL entry happen in the same cycle, REQ=0.
- Timed phases (GRN_MIN, YEL, RED):
  - CNT is loaded with T_x on entry.
  - CNT decrements on each TICK.
  - A TICK with CNT==1 leaves the phase, so each phase lasts exactly T_x TICKs.
  - All lamps, CNT and REQ are registered and update in the cycle after the deciding posedge.
- States (lamps G/E/R):
  - GRN_MIN (G): on TICK with CNT==1:
    - night -> YEL with nightflag=1;
    - else REQ -> YEL;
    - else -> GRN_WAIT.
  - GRN_WAIT (G, CNT=0): on TICK:
    - night -> YEL with nightflag=1;
    - else REQ -> YEL;
    - else stay.
  - YEL (E): on expiry, nightflag -> NIGHT, else -> RED (CNT=T_R).
  - RED (R): on expiry, night -> NIGHT, else -> GRN_MIN (CNT=T_GMIN).
  - NIGHT (G=R=off, CNT=0):
    - Yellow toggles every T_BLINK TICKs, starting on (lit) at entry.
    - Not night, sampled on TICK -> RED (full T_R), then normal cycle.
    - nightflag cleared on entry.
- Night has priority over REQ when both are present at a GRN decision. REQ is still cleared at YEL entry.
- Illegal state encodings go to GRN_MIN with CNT=T_GMIN on the next cycle.
- Exactly one lamp is lit in every non-NIGHT state. G and R are never lit together.

Test Plan:
Bench parameters: PDIV=4, CW=4, T_GMIN=3, T_Y=2, T_R=5, T_BLINK=2.
1. Reset held 2 cycles then released -> nGQ=0, nEQ=1, nRQ=1, CNT=3, REQ=0, nTY=0. CNT reads 2, 1 on TICKs 1, 2. At TICK 3: GRN_WAIT, CNT=0, nTY=1.
2. nB pulsed low during GRN_MIN (after TICK 1) -> REQ=1 within 4 cycles. At TICK 3: nEQ=0, REQ=0, CNT=2. Yellow for 8 C cycles, then nRQ=0 with CNT=5 for 20 cycles, then back to GRN_MIN with CNT=3.
3. No press for 100 cycles -> green held, CNT=0. Then press -> YEL at the first TICK after REQ=1.
4. nB pressed during RED -> REQ stays 0. After RED, green remains in GRN_WAIT with no further press.
5. nNight=0 in GRN_WAIT -> YEL 2 TICKs, then NIGHT. nEQ toggles every 8 cycles; nGQ=nRQ=1. nNight=1 -> RED 5 TICKs, then GRN_MIN.
6. nR=0 mid-RED with CNT=3 -> next cycle shows GRN_MIN, nGQ=0, CNT=3, REQ=0, prescaler restarts from 0.
